ysyx_25040111_mem_arbiter: RTL

- Shares the single core memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Each requester has its own req/ack handshake. The block arbitrates between them and latches the winner's request.
- It sequences one transaction at a time on the downstream port (address phase, then data phase), returns data and error to the owner, and enforces a response timeout.

---
 rtl/ysyx_25040111_mem_arbiter_if.sv | 58 +++++
 rtl/ysyx_25040111_mem_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040111_mem_arbiter_if
// Brief    : IFU / LSU request ports and downstream memory port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_25040111_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        ls_req;
    logic        ls_wen;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wmask;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        ls_err;

    logic        m_req;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_err;

    logic        busy;
    logic        owner;

    // Arbiter side: masters the downstream port, answers both requesters.
    modport master (
        input  if_req, if_addr,
        output if_ack, if_rdata, if_err,
        input  ls_req, ls_wen, ls_addr, ls_wdata, ls_wmask,
        output ls_ack, ls_rdata, ls_err,
        output m_req, m_wen, m_addr, m_wdata, m_wmask,
        input  m_gnt, m_rvalid, m_rdata, m_err,
        output busy, owner
    );

    // Environment side: requesters plus the memory slave.
    modport slave (
        output if_req, if_addr,
        input  if_ack, if_rdata, if_err,
        output ls_req, ls_wen, ls_addr, ls_wdata, ls_wmask,
        input  ls_ack, ls_rdata, ls_err,
        input  m_req, m_wen, m_addr, m_wdata, m_wmask,
        output m_gnt, m_rvalid, m_rdata, m_err,
        input  busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_25040111_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040111_mem_arbiter
// Brief    : Shares one memory port between IFU and LSU, one transaction at
//            a time, with a response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25040111_mem_arbiter #(
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    ysyx_25040111_mem_arbiter_if.master   bus
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_addr = 2'd1;
    localparam logic [1:0] c_data = 2'd2;
    localparam logic [1:0] c_resp = 2'd3;

    localparam logic [CNT_W-1:0] c_timeout  = CNT_W'(TIMEOUT);
    localparam logic             c_lsu_prio = (ARB_MODE == 1);
    localparam logic             c_to_en    = (TIMEOUT != 0);

    logic [1:0]       r_state, w_state_nxt;
    logic             r_last_owner, w_last_owner_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic             r_m_req, w_m_req_nxt;
    logic             r_m_wen, w_m_wen_nxt;
    logic [31:0]      r_m_addr, w_m_addr_nxt;
    logic [31:0]      r_m_wdata, w_m_wdata_nxt;
    logic [3:0]       r_m_wmask, w_m_wmask_nxt;
    logic             r_if_ack, w_if_ack_nxt;
    logic [31:0]      r_if_rdata, w_if_rdata_nxt;
    logic             r_if_err, w_if_err_nxt;
    logic             r_ls_ack, w_ls_ack_nxt;
    logic [31:0]      r_ls_rdata, w_ls_rdata_nxt;
    logic             r_ls_err, w_ls_err_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_owner, w_owner_nxt;

    logic             w_any_req;
    logic             w_grant_ls;
    logic             w_expire;
    logic             w_rsp_ok;
    logic             w_rsp_to;

    assign w_any_req  = bus.if_req | bus.ls_req;
    // LSU wins when alone, under fixed priority, or when IFU had the last grant.
    assign w_grant_ls = bus.ls_req & (~bus.if_req | c_lsu_prio | ~r_last_owner);
    assign w_expire   = c_to_en && ((r_cnt + CNT_W'(1)) == c_timeout);

    // State register plus the registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_idle;
            r_last_owner <= 1'b1;
            r_cnt        <= '0;
            r_m_req      <= 1'b0;
            r_m_wen      <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_m_wmask    <= '0;
            r_if_ack     <= 1'b0;
            r_if_rdata   <= '0;
            r_if_err     <= 1'b0;
            r_ls_ack     <= 1'b0;
            r_ls_rdata   <= '0;
            r_ls_err     <= 1'b0;
            r_busy       <= 1'b0;
            r_owner      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_cnt        <= w_cnt_nxt;
            r_m_req      <= w_m_req_nxt;
            r_m_wen      <= w_m_wen_nxt;
            r_m_addr     <= w_m_addr_nxt;
            r_m_wdata    <= w_m_wdata_nxt;
            r_m_wmask    <= w_m_wmask_nxt;
            r_if_ack     <= w_if_ack_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_if_err     <= w_if_err_nxt;
            r_ls_ack     <= w_ls_ack_nxt;
            r_ls_rdata   <= w_ls_rdata_nxt;
            r_ls_err     <= w_ls_err_nxt;
            r_busy       <= w_busy_nxt;
            r_owner      <= w_owner_nxt;
        end
    end

    // Next state; a real response beats a timeout landing in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_rsp_ok    = 1'b0;
        w_rsp_to    = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_any_req) w_state_nxt = c_addr;
            end
            c_addr: begin
                w_rsp_ok = bus.m_gnt & bus.m_rvalid;
                w_rsp_to = ~(bus.m_gnt & bus.m_rvalid) & w_expire;
                if ((bus.m_gnt & bus.m_rvalid) | w_expire) w_state_nxt = c_resp;
                else if (bus.m_gnt)                      w_state_nxt = c_data;
            end
            c_data: begin
                w_rsp_ok = bus.m_rvalid;
                w_rsp_to = ~bus.m_rvalid & w_expire;
                if (bus.m_rvalid | w_expire) w_state_nxt = c_resp;
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        w_last_owner_nxt = r_last_owner;
        w_cnt_nxt        = r_cnt;
        w_m_req_nxt      = r_m_req;
        w_m_wen_nxt      = r_m_wen;
        w_m_addr_nxt     = r_m_addr;
        w_m_wdata_nxt    = r_m_wdata;
        w_m_wmask_nxt    = r_m_wmask;
        w_if_ack_nxt     = 1'b0;
        w_if_rdata_nxt   = r_if_rdata;
        w_if_err_nxt     = r_if_err;
        w_ls_ack_nxt     = 1'b0;
        w_ls_rdata_nxt   = r_ls_rdata;
        w_ls_err_nxt     = r_ls_err;
        w_owner_nxt      = r_owner;
        w_busy_nxt       = (w_state_nxt != c_idle);

        case (r_state)
            c_idle: begin
                if (w_any_req) begin
                    w_m_req_nxt      = 1'b1;
                    w_cnt_nxt        = '0;
                    w_owner_nxt      = w_grant_ls;
                    w_last_owner_nxt = w_grant_ls;
                    if (w_grant_ls) begin
                        w_m_wen_nxt   = bus.ls_wen;
                        w_m_addr_nxt  = bus.ls_addr;
                        w_m_wdata_nxt = bus.ls_wdata;
                        w_m_wmask_nxt = bus.ls_wen ? bus.ls_wmask : 4'h0;
                    end else begin
                        w_m_wen_nxt   = 1'b0;
                        w_m_addr_nxt  = bus.if_addr;
                        w_m_wdata_nxt = '0;
                        w_m_wmask_nxt = 4'h0;
                    end
                end
            end
            c_addr, c_data: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if ((r_state == c_addr) && bus.m_gnt) w_m_req_nxt = 1'b0;
                if (w_rsp_ok | w_rsp_to) begin
                    w_m_req_nxt = 1'b0;
                    if (r_owner) begin
                        w_ls_ack_nxt   = 1'b1;
                        w_ls_rdata_nxt = w_rsp_to ? 32'h0 : bus.m_rdata;
                        w_ls_err_nxt   = w_rsp_to | bus.m_err;
                    end else begin
                        w_if_ack_nxt   = 1'b1;
                        w_if_rdata_nxt = w_rsp_to ? 32'h0 : bus.m_rdata;
                        w_if_err_nxt   = w_rsp_to | bus.m_err;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.m_req    = r_m_req;
    assign bus.m_wen    = r_m_wen;
    assign bus.m_addr   = r_m_addr;
    assign bus.m_wdata  = r_m_wdata;
    assign bus.m_wmask  = r_m_wmask;
    assign bus.if_ack   = r_if_ack;
    assign bus.if_rdata = r_if_rdata;
    assign bus.if_err   = r_if_err;
    assign bus.ls_ack   = r_ls_ack;
    assign bus.ls_rdata = r_ls_rdata;
    assign bus.ls_err   = r_ls_err;
    assign bus.busy     = r_busy;
    assign bus.owner    = r_owner;

endmodule
`default_nettype wire
